writeback_stream: RTL and testbench

//  Parametrised successor to the single-counter writeback stage: buffers result words from the

---
 rtl/writeback_stream.sv | 143 ++++++++++++++
 tb/tb_writeback_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stream.sv
// Writeback stage: buffers result words in a small FIFO and streams them to output
// memory at base + i*stride, with job start/length control and memory back-pressure.
module writeback_stream #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [ADDR_W-1:0] cfg_count,
    input  logic [DATA_W-1:0] data,
    input  logic              en,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_en,
    input  logic              out_mem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] next_addr, stride, count, accepted_in, written;

    logic fifo_empty, fifo_full, start_ok, push, load_slot, pop, bypass, fifo_wr, write_ack;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign start_ok  = (state == IDLE) && start;
    assign in_ready  = (state == RUN) && !fifo_full && (accepted_in < count);
    assign push      = en && in_ready;
    assign write_ack = out_mem_en && out_mem_ready;
    assign load_slot = (state == RUN) && (!out_mem_en || out_mem_ready);
    assign pop       = load_slot && !fifo_empty;
    // An incoming word skips the FIFO when it is empty and the output register is free.
    assign bypass    = load_slot && fifo_empty && push;
    assign fifo_wr   = push && !bypass;

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cfg_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (write_ack && ((written + ADDR_W'(1)) == count)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            next_addr    <= '0;
            stride       <= '0;
            count        <= '0;
            accepted_in  <= '0;
            written      <= '0;
            overflow     <= 1'b0;
            out_mem_en   <= 1'b0;
            out_mem_data <= '0;
            out_mem_addr <= '0;
        end else if (start_ok) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            next_addr   <= cfg_base;
            stride      <= cfg_stride;
            count       <= cfg_count;
            accepted_in <= '0;
            written     <= '0;
            overflow    <= 1'b0;
            out_mem_en  <= 1'b0;
        end else begin
            if (en && !in_ready) begin
                overflow <= 1'b1;
            end
            if (push) begin
                accepted_in <= accepted_in + ADDR_W'(1);
            end
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (write_ack) begin
                written <= written + ADDR_W'(1);
            end
            // The output register reloads only once the current request has been taken.
            if (state != RUN) begin
                out_mem_en <= 1'b0;
            end else if (load_slot) begin
                if (pop || bypass) begin
                    out_mem_data <= pop ? fifo_mem[rd_ptr[PTR_W-1:0]] : data;
                    out_mem_addr <= next_addr;
                    next_addr    <= next_addr + stride;
                    out_mem_en   <= 1'b1;
                end else begin
                    out_mem_en <= 1'b0;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stream.sv
// Directed bench for writeback_stream: streaming, back-pressure, overflow, address wrap,
// empty jobs, ignored restarts and mid-job reset, each step checked against hand values.
module tb_writeback_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_base, cfg_stride, cfg_count;
    logic [17:0] data;
    logic        en;
    logic        in_ready;
    logic [17:0] out_mem_data;
    logic [15:0] out_mem_addr;
    logic        out_mem_en;
    logic        out_mem_ready;
    logic        busy, done, overflow;

    int total = 0;
    int bad   = 0;

    writeback_stream #(.DATA_W(18), .ADDR_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
        .data(data), .en(en), .in_ready(in_ready),
        .out_mem_data(out_mem_data), .out_mem_addr(out_mem_addr), .out_mem_en(out_mem_en),
        .out_mem_ready(out_mem_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_mem_en && out_mem_ready) begin
            $display("[TB] Writeback: %h <-- %0d", out_mem_addr, out_mem_data);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic [17:0] d, input logic r);
        start         = s;
        en            = e;
        data          = d;
        out_mem_ready = r;
    endtask

    task automatic setConfig(input logic [15:0] b, input logic [15:0] st, input logic [15:0] c);
        cfg_base   = b;
        cfg_stride = st;
        cfg_count  = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic [15:0] a, input logic [17:0] d);
        checkOutput({tag, ".en"}, 32'(out_mem_en), 32'd1);
        checkOutput({tag, ".addr"}, 32'(out_mem_addr), 32'(a));
        checkOutput({tag, ".data"}, 32'(out_mem_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        setConfig(16'h0, 16'h0, 16'h0);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset.en", 32'(out_mem_en), 32'd0);
        checkOutput("reset.addr", 32'(out_mem_addr), 32'd0);
        checkOutput("reset.data", 32'(out_mem_data), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.ovf", 32'(overflow), 32'd0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // 1: contiguous stream with memory always ready
        $display("[TB] stream base=0x0100 stride=1 count=4");
        setConfig(16'h0100, 16'd1, 16'd4);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t1.busy", 32'(busy), 32'd1);
        checkOutput("t1.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 18'(10 + i), 1'b1);
            nextCycle();
            checkWrite("t1.w", 16'(16'h0100 + i), 18'(10 + i));
        end
        checkOutput("t1.in_ready_cnt", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t1.done", 32'(done), 32'd1);
        checkOutput("t1.busy_done", 32'(busy), 32'd1);
        checkOutput("t1.en_done", 32'(out_mem_en), 32'd0);
        nextCycle();
        checkOutput("t1.done_clr", 32'(done), 32'd0);
        checkOutput("t1.idle", 32'(busy), 32'd0);

        // 2: back-pressure holds the first request stable
        $display("[TB] back-pressure base=0 stride=3 count=3");
        setConfig(16'h0000, 16'd3, 16'd3);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) applyStimulus(1'b0, 1'b1, 18'(10 + i), 1'b0);
            else       applyStimulus(1'b0, 1'b0, 18'd0, 1'b0);
            nextCycle();
            checkWrite("t2.hold", 16'h0000, 18'd10);
        end
        checkOutput("t2.in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkWrite("t2.w1", 16'd3, 18'd11);
        nextCycle();
        checkWrite("t2.w2", 16'd6, 18'd12);
        nextCycle();
        checkOutput("t2.done", 32'(done), 32'd1);
        nextCycle();
        checkOutput("t2.idle", 32'(busy), 32'd0);

        // 3: fill FIFO plus output register, then overflow
        $display("[TB] overflow count=20");
        setConfig(16'h0200, 16'd2, 16'd20);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
        nextCycle();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t3.in_ready", 32'(in_ready), (i < 9) ? 32'd1 : 32'd0);
            checkOutput("t3.ovf_pre", 32'(overflow), 32'd0);
            applyStimulus(1'b0, 1'b1, 18'(100 + i), 1'b0);
            nextCycle();
        end
        checkOutput("t3.ovf", 32'(overflow), 32'd1);
        checkWrite("t3.head", 16'h0200, 18'd100);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        for (int k = 1; k < 9; k++) begin
            nextCycle();
            checkWrite("t3.drain", 16'(16'h0200 + 2 * k), 18'(100 + k));
        end
        nextCycle();
        checkOutput("t3.empty", 32'(out_mem_en), 32'd0);
        checkOutput("t3.busy", 32'(busy), 32'd1);
        for (int j = 0; j < 11; j++) begin
            applyStimulus(1'b0, 1'b1, 18'(200 + j), 1'b1);
            nextCycle();
            checkWrite("t3.tail", 16'(16'h0200 + 2 * (9 + j)), 18'(200 + j));
        end
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t3.done", 32'(done), 32'd1);
        checkOutput("t3.ovf_done", 32'(overflow), 32'd1);
        nextCycle();
        checkOutput("t3.ovf_idle", 32'(overflow), 32'd1);

        // 4: address wrap at the top of the address space
        $display("[TB] address wrap base=0xFFFE");
        setConfig(16'hFFFE, 16'd1, 16'd4);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t4.ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 18'(50 + i), 1'b1);
            nextCycle();
            checkWrite("t4.w", 16'(16'hFFFE + i), 18'(50 + i));
        end
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t4.done", 32'(done), 32'd1);
        nextCycle();

        // 5: empty job, then a restart attempt while busy
        $display("[TB] empty job and ignored start");
        setConfig(16'h0777, 16'd1, 16'd0);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t5.busy", 32'(busy), 32'd1);
        checkOutput("t5.done", 32'(done), 32'd1);
        checkOutput("t5.en", 32'(out_mem_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t5.busy_clr", 32'(busy), 32'd0);
        checkOutput("t5.done_clr", 32'(done), 32'd0);
        setConfig(16'h0300, 16'd4, 16'd2);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
        nextCycle();
        setConfig(16'h0500, 16'd8, 16'd1);
        applyStimulus(1'b1, 1'b1, 18'd70, 1'b1);
        nextCycle();
        checkWrite("t5.w0", 16'h0300, 18'd70);
        applyStimulus(1'b1, 1'b1, 18'd71, 1'b1);
        nextCycle();
        checkWrite("t5.w1", 16'h0304, 18'd71);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t5.job_done", 32'(done), 32'd1);
        nextCycle();
        checkOutput("t5.idle", 32'(busy), 32'd0);

        // 6: reset in the middle of a job abandons the pending write
        $display("[TB] mid-job reset");
        setConfig(16'h0400, 16'd1, 16'd5);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 18'(80 + i), 1'b1);
            nextCycle();
        end
        checkWrite("t6.pre", 16'h0402, 18'd82);
        applyStimulus(1'b0, 1'b1, 18'd83, 1'b0);
        nextCycle();
        checkWrite("t6.held", 16'h0402, 18'd82);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b0);
        nextCycle();
        checkOutput("t6.en", 32'(out_mem_en), 32'd0);
        checkOutput("t6.addr", 32'(out_mem_addr), 32'd0);
        checkOutput("t6.data", 32'(out_mem_data), 32'd0);
        checkOutput("t6.busy", 32'(busy), 32'd0);
        checkOutput("t6.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        setConfig(16'h0600, 16'd1, 16'd1);
        applyStimulus(1'b1, 1'b0, 18'd0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 18'd90, 1'b1);
        nextCycle();
        checkWrite("t6.new", 16'h0600, 18'd90);
        applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("t6.done", 32'(done), 32'd1);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
